// File: rtl/xadc_multichan_sampler.sv
// xadc_multichan_sampler: round-robin DRP reader over consecutive XADC aux channels.
// Each end-of-conversion triggers one DRP read; 2**AVG_LOG2 reads per channel are
// boxcar-averaged and published both as a sample pulse and in a per-channel register bank.
module xadc_multichan_sampler #(
    parameter int FIRST_AUX = 6,
    parameter int NUM_CH    = 4,
    parameter int AVG_LOG2  = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 eoc_in,
    output logic [6:0]           daddr_out,
    output logic                 den_out,
    output logic                 dwe_out,
    output logic [15:0]          di_out,
    input  logic [15:0]          do_in,
    input  logic                 drdy_in,
    output logic [11:0]          sample_data,
    output logic [3:0]           sample_ch,
    output logic                 sample_valid,
    output logic [NUM_CH*12-1:0] ch_data,
    output logic                 err_timeout,
    output logic                 err_overrun
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int NSAMP = 1 << AVG_LOG2;
    localparam logic [6:0]       BASE_ADDR = 7'(16 + FIRST_AUX);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NSAMP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [7:0]       TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_CH   = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           chIdx_q, chIdx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [7:0]           timer_q, timer_d;
    logic [11:0]          sampleData_q, sampleData_d;
    logic [3:0]           sampleCh_q, sampleCh_d;
    logic                 sampleValid_q, sampleValid_d;
    logic [NUM_CH*12-1:0] chData_q, chData_d;
    logic                 overrun_q, overrun_d;
    logic                 timeoutHit;
    logic                 unusedLowBits;

    // The low nibble of the left-justified DRP word carries no conversion data.
    assign unusedLowBits = ^do_in[3:0];

    // Read-only DRP master: the write path is held inactive.
    assign dwe_out      = 1'b0;
    assign di_out       = 16'h0000;
    assign den_out      = (state_q == REQ);
    assign daddr_out    = BASE_ADDR + {3'b000, chIdx_q};
    assign sample_data  = sampleData_q;
    assign sample_ch    = sampleCh_q;
    assign sample_valid = sampleValid_q;
    assign ch_data      = chData_q;
    assign err_timeout  = timeoutHit;
    assign err_overrun  = overrun_q;

    // Next-state logic: request, wait for drdy or give up, and publish the average.
    always_comb begin
        state_d       = state_q;
        chIdx_d       = chIdx_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        timer_d       = timer_q;
        sampleData_d  = sampleData_q;
        sampleCh_d    = sampleCh_q;
        sampleValid_d = 1'b0;
        chData_d      = chData_q;
        overrun_d     = eoc_in && (state_q != IDLE);
        timeoutHit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (eoc_in) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                timer_d = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (drdy_in) begin
                    acc_d   = acc_q + ACC_W'(do_in[15:4]);
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = (cnt_q == LAST_CNT) ? DONE : IDLE;
                end else if (timer_q == TMO_LAST) begin
                    timeoutHit = 1'b1;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DONE: begin
                sampleData_d  = acc_q[AVG_LOG2 +: 12];
                sampleCh_d    = chIdx_q;
                chData_d[int'(chIdx_q)*12 +: 12] = acc_q[AVG_LOG2 +: 12];
                sampleValid_d = 1'b1;
                acc_d         = '0;
                cnt_d         = '0;
                chIdx_d       = (chIdx_q == LAST_CH) ? 4'd0 : chIdx_q + 4'd1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any read in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            chIdx_q       <= 4'd0;
            cnt_q         <= '0;
            acc_q         <= '0;
            timer_q       <= 8'd0;
            sampleData_q  <= 12'd0;
            sampleCh_q    <= 4'd0;
            sampleValid_q <= 1'b0;
            chData_q      <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            chIdx_q       <= chIdx_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            timer_q       <= timer_d;
            sampleData_q  <= sampleData_d;
            sampleCh_q    <= sampleCh_d;
            sampleValid_q <= sampleValid_d;
            chData_q      <= chData_d;
            overrun_q     <= overrun_d;
        end
    end

endmodule

// File: tb/tb_xadc_multichan_sampler.sv
// Bench for xadc_multichan_sampler: scripted DRP transactions schedule the expected
// outputs per cycle from the channel/averaging rules; one process compares every cycle.
module tb_xadc_multichan_sampler;

    localparam int FIRST_AUX = 6;
    localparam int NUM_CH    = 4;
    localparam int AVG_LOG2  = 2;
    localparam int TIMEOUT   = 64;
    localparam int NSAMP     = 4;
    localparam int MAXC      = 30000;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 eoc_in;
    logic [6:0]           daddr_out;
    logic                 den_out;
    logic                 dwe_out;
    logic [15:0]          di_out;
    logic [15:0]          do_in;
    logic                 drdy_in;
    logic [11:0]          sample_data;
    logic [3:0]           sample_ch;
    logic                 sample_valid;
    logic [NUM_CH*12-1:0] ch_data;
    logic                 err_timeout;
    logic                 err_overrun;

    xadc_multichan_sampler #(
        .FIRST_AUX(FIRST_AUX),
        .NUM_CH(NUM_CH),
        .AVG_LOG2(AVG_LOG2),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .eoc_in(eoc_in),
        .daddr_out(daddr_out),
        .den_out(den_out),
        .dwe_out(dwe_out),
        .di_out(di_out),
        .do_in(do_in),
        .drdy_in(drdy_in),
        .sample_data(sample_data),
        .sample_ch(sample_ch),
        .sample_valid(sample_valid),
        .ch_data(ch_data),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun)
    );

    // Free-running clock and cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected events, indexed by cycle
    bit         expDen   [MAXC];
    logic [6:0] expAddr  [MAXC];
    bit         expValid [MAXC];
    logic [11:0] expSData[MAXC];
    logic [3:0] expSCh   [MAXC];
    bit         expTmo   [MAXC];
    bit         expOvr   [MAXC];
    bit         rstEv    [MAXC];

    // Transaction-level model: channel pointer and samples gathered so far
    int mCh = 0;
    int samples[$];

    // Held output model and observations
    logic [11:0]          heldData;
    logic [3:0]           heldCh;
    logic [11:0]          chModel[NUM_CH];
    logic [NUM_CH*12-1:0] expCh;
    logic [6:0]           addrLog[$];
    int lastDenCycle = 0;
    int lastTmoCycle = 0;
    int ovrSeen = 0;

    int nChecks = 0;
    int nFail = 0;
    bit checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // One DRP read: eoc now, drdy after 'delay' WAIT cycles (delay > TIMEOUT withholds it)
    task automatic applyStimulus(input logic [11:0] val, input int delay, input bit pokeOvr, input bit pokeDone);
        int  n;
        int  m;
        int  sum;
        bit  complete;
        n = cyc;
        eoc_in = 1'b1;
        expDen[n+1]  = 1'b1;
        expAddr[n+1] = 7'(16 + FIRST_AUX + mCh);
        nextCycle();
        eoc_in = 1'b0;
        if (delay <= TIMEOUT) begin
            for (int i = 1; i <= delay; i++) begin
                nextCycle();
                eoc_in = pokeOvr && (i == 1);
                if (eoc_in) expOvr[cyc+1] = 1'b1;
                if (i == delay) begin
                    drdy_in = 1'b1;
                    do_in   = {val, 4'($urandom)};
                end
            end
            m = cyc;
            samples.push_back(int'(val));
            complete = (samples.size() == NSAMP);
            nextCycle();
            eoc_in  = 1'b0;
            drdy_in = 1'b0;
            if (complete) begin
                sum = 0;
                foreach (samples[k]) sum += samples[k];
                expValid[m+2] = 1'b1;
                expSData[m+2] = 12'(sum / NSAMP);
                expSCh[m+2]   = 4'(mCh);
                samples.delete();
                mCh = (mCh + 1) % NUM_CH;
                if (pokeDone) begin
                    eoc_in = 1'b1;
                    expOvr[m+2] = 1'b1;
                end
                nextCycle();
                eoc_in = 1'b0;
            end
        end else begin
            for (int i = 1; i <= TIMEOUT; i++) begin
                nextCycle();
                eoc_in = pokeOvr && (i == 1);
                if (eoc_in) expOvr[cyc+1] = 1'b1;
            end
            expTmo[cyc] = 1'b1;
            samples.delete();
            nextCycle();
            eoc_in = 1'b0;
        end
    endtask

    // Idle cycles, optionally with stray drdy pulses that must be ignored
    task automatic idleGap(input int k, input bit spurious);
        for (int i = 0; i < k; i++) begin
            drdy_in = spurious && ($urandom_range(0, 1) == 1);
            do_in   = 16'($urandom);
            nextCycle();
        end
        drdy_in = 1'b0;
    endtask

    // Every-cycle comparison against the scheduled expectations
    always @(negedge clk) begin
        if (checkEn) begin
            if (cyc >= MAXC) begin
                checkOutput("cycle_budget", 64'(cyc), 64'(MAXC - 1));
            end else begin
                if (rstEv[cyc]) begin
                    heldData = 12'd0;
                    heldCh   = 4'd0;
                    for (int k = 0; k < NUM_CH; k++) chModel[k] = 12'd0;
                end
                if (expValid[cyc]) begin
                    heldData = expSData[cyc];
                    heldCh   = expSCh[cyc];
                    chModel[expSCh[cyc]] = expSData[cyc];
                end
                for (int k = 0; k < NUM_CH; k++) expCh[12*k +: 12] = chModel[k];
                checkOutput("den_out", 64'(den_out), 64'(expDen[cyc]));
                if (expDen[cyc]) checkOutput("daddr_out", 64'(daddr_out), 64'(expAddr[cyc]));
                checkOutput("sample_valid", 64'(sample_valid), 64'(expValid[cyc]));
                checkOutput("err_timeout", 64'(err_timeout), 64'(expTmo[cyc]));
                checkOutput("err_overrun", 64'(err_overrun), 64'(expOvr[cyc]));
                checkOutput("sample_data", 64'(sample_data), 64'(heldData));
                checkOutput("sample_ch", 64'(sample_ch), 64'(heldCh));
                checkOutput("ch_data", 64'(ch_data), 64'(expCh));
                checkOutput("dwe_di", 64'({dwe_out, di_out}), 64'(0));
                if (den_out) begin
                    lastDenCycle = cyc;
                    addrLog.push_back(daddr_out);
                end
                if (err_timeout) lastTmoCycle = cyc;
                if (err_overrun) ovrSeen++;
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        logic [6:0] addrPin[17];
        int idx;
        int ovr0;
        heldData = 12'd0;
        heldCh   = 4'd0;
        for (int k = 0; k < NUM_CH; k++) chModel[k] = 12'd0;
        rst_n = 1'b0;
        eoc_in = 1'b0;
        drdy_in = 1'b0;
        do_in = 16'h0000;

        // Reset held with eoc and drdy toggling
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            eoc_in  = ~eoc_in;
            drdy_in = ~drdy_in;
            do_in   = 16'($urandom);
            checkOutput("rst_den", 64'(den_out), 64'(0));
            checkOutput("rst_ch_data", 64'(ch_data), 64'(0));
            checkOutput("rst_pulses", 64'({sample_valid, err_timeout, err_overrun}), 64'(0));
            checkOutput("rst_daddr", 64'(daddr_out), 64'(7'h16));
            checkOutput("rst_sample", 64'({sample_data, sample_ch}), 64'(0));
        end
        eoc_in = 1'b0;
        drdy_in = 1'b0;
        rst_n = 1'b1;
        checkEn = 1'b1;
        nextCycle();

        // Constant 12'hABC on every read, one full scan
        for (int i = 0; i < 16; i++) begin
            applyStimulus(12'hABC, 1 + (i % 3), 1'b0, 1'b0);
            idleGap(i % 2, 1'b0);
        end
        // Averaging on ch0: 1,2,3,4 -> 10>>2 = 2
        applyStimulus(12'h001, 2, 1'b0, 1'b0);
        applyStimulus(12'h002, 1, 1'b0, 1'b0);
        applyStimulus(12'h003, 3, 1'b0, 1'b0);
        applyStimulus(12'h004, 1, 1'b0, 1'b0);
        checkOutput("avg_sample_data", 64'(sample_data), 64'(12'h002));
        checkOutput("avg_sample_ch", 64'(sample_ch), 64'(0));
        checkOutput("avg_ch_data", 64'(ch_data), 64'({12'hABC, 12'hABC, 12'hABC, 12'h002}));
        for (int i = 0; i < 16; i++) addrPin[i] = 7'h16 + 7'(i / 4);
        addrPin[16] = 7'h16;
        checkOutput("addr_count", 64'(addrLog.size()), 64'(20));
        if (addrLog.size() >= 17) begin
            for (int i = 0; i < 17; i++) checkOutput("addr_sequence", 64'(addrLog[i]), 64'(addrPin[i]));
        end

        // Timeout on ch1 after one partial sample, then a fresh average
        applyStimulus(12'hFFF, 3, 1'b0, 1'b0);
        applyStimulus(12'h000, 100, 1'b0, 1'b0);
        checkOutput("tmo_latency", 64'(lastTmoCycle - lastDenCycle), 64'(64));
        idx = addrLog.size();
        applyStimulus(12'h100, 64, 1'b0, 1'b0);
        applyStimulus(12'h200, 1, 1'b0, 1'b0);
        applyStimulus(12'h300, 2, 1'b0, 1'b0);
        applyStimulus(12'h404, 5, 1'b0, 1'b0);
        if (addrLog.size() > idx) checkOutput("tmo_reread_addr", 64'(addrLog[idx]), 64'(7'h17));
        else checkOutput("tmo_reread_present", 64'(addrLog.size()), 64'(idx + 1));
        checkOutput("tmo_fresh_avg", 64'(sample_data), 64'(12'h281));
        checkOutput("tmo_fresh_ch", 64'(sample_ch), 64'(1));

        // Overrun one cycle after den_out
        ovr0 = ovrSeen;
        applyStimulus(12'h123, 4, 1'b1, 1'b0);
        checkOutput("overrun_once", 64'(ovrSeen - ovr0), 64'(1));

        // Reset in the middle of a WAIT, then a late drdy
        eoc_in = 1'b1;
        expDen[cyc+1]  = 1'b1;
        expAddr[cyc+1] = 7'(16 + FIRST_AUX + mCh);
        nextCycle();
        eoc_in = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b0;
        rstEv[cyc+1] = 1'b1;
        mCh = 0;
        samples.delete();
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        drdy_in = 1'b1;
        do_in = 16'($urandom);
        nextCycle();
        drdy_in = 1'b0;
        idleGap(3, 1'b0);
        checkOutput("midreset_ch_data", 64'(ch_data), 64'(0));
        idx = addrLog.size();
        applyStimulus(12'h555, 1, 1'b0, 1'b0);
        if (addrLog.size() > idx) checkOutput("midreset_addr", 64'(addrLog[idx]), 64'(7'h16));
        else checkOutput("midreset_addr_present", 64'(addrLog.size()), 64'(idx + 1));

        // Randomized traffic: delays straddle the timeout, overruns and stray drdy
        for (int i = 0; i < 150; i++) begin
            applyStimulus(12'($urandom), $urandom_range(1, 72),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
            idleGap($urandom_range(0, 3), 1'b1);
        end
        idleGap(4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
